// File: rtl/fifo_sum_ctrl.sv
// fifo_sum_ctrl: sequences two external row-delay FIFOs so that each byte of
// row 2 onward yields the column sum of three vertically adjacent bytes.
module fifo_sum_ctrl #(
    parameter int COL_MAX = 5,
    parameter int ROW_MAX = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       fifo1_wr_en,
    output logic [7:0] fifo1_din,
    output logic       fifo1_rd_en,
    input  logic [7:0] fifo1_dout,
    input  logic       fifo1_empty,
    output logic       fifo2_wr_en,
    output logic [7:0] fifo2_din,
    output logic       fifo2_rd_en,
    input  logic [7:0] fifo2_dout,
    input  logic       fifo2_empty,
    output logic [9:0] po_sum,
    output logic       po_flag,
    output logic       err
);

    localparam int CW = $clog2(COL_MAX + 1);
    localparam int RW = $clog2(ROW_MAX + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL_MAX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW_MAX - 1);

    typedef enum logic [1:0] {WR_F1, WR_F2, SUM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_cnt_q, col_cnt_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic            f1_wr_q, f1_wr_d;
    logic [7:0]      f1_din_q, f1_din_d;
    logic            f2_wr_q, f2_wr_d;
    logic [7:0]      f2_din_q, f2_din_d;
    logic            rd_q, rd_d;          // read strobe, cycle T+1
    logic            rd_wb_q, rd_wb_d;    // row is to be written back (not last row)
    logic            s2_q, s2_d;          // FIFO data valid, cycle T+2
    logic            s2_wb_q, s2_wb_d;
    logic [7:0]      data_d1_q, data_d1_d;
    logic [9:0]      po_sum_q, po_sum_d;
    logic            po_flag_q, po_flag_d;
    logic            err_q, err_d;

    logic last_col;
    logic last_row;

    assign last_col = (col_cnt_q == COL_LAST);
    assign last_row = (row_cnt_q == ROW_LAST);

    // Next-state, counters and pipeline stage computation
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        f1_wr_d   = 1'b0;
        f1_din_d  = f1_din_q;
        f2_wr_d   = 1'b0;
        f2_din_d  = f2_din_q;
        rd_d      = 1'b0;
        rd_wb_d   = rd_wb_q;
        s2_d      = rd_q;
        s2_wb_d   = rd_wb_q;
        data_d1_d = data_d1_q;
        po_sum_d  = po_sum_q;
        po_flag_d = s2_q;
        err_d     = err_q;

        if (pi_flag) begin
            col_cnt_d = last_col ? '0 : col_cnt_q + CW'(1);
            if (last_col) begin
                row_cnt_d = last_row ? '0 : row_cnt_q + RW'(1);
            end
            unique case (state_q)
                WR_F1: begin
                    f1_wr_d  = 1'b1;
                    f1_din_d = pi_data;
                    if (last_col) state_d = WR_F2;
                end
                WR_F2: begin
                    f2_wr_d  = 1'b1;
                    f2_din_d = pi_data;
                    if (last_col) state_d = SUM;
                end
                SUM: begin
                    rd_d      = 1'b1;
                    rd_wb_d   = !last_row;
                    data_d1_d = pi_data;
                    if (last_col && last_row) state_d = WR_F1;
                end
                default: state_d = WR_F1;
            endcase
        end

        // data_d1 still holds the new byte at T+2, so the sum is formed there
        // and registered, presenting po_sum/po_flag at T+3.
        if (s2_q) begin
            po_sum_d = 10'(fifo1_dout) + 10'(fifo2_dout) + 10'(data_d1_q);
        end

        if (rd_q && (fifo1_empty || fifo2_empty)) begin
            err_d = 1'b1;
        end
    end

    // State and pipeline registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= WR_F1;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            f1_wr_q   <= 1'b0;
            f1_din_q  <= '0;
            f2_wr_q   <= 1'b0;
            f2_din_q  <= '0;
            rd_q      <= 1'b0;
            rd_wb_q   <= 1'b0;
            s2_q      <= 1'b0;
            s2_wb_q   <= 1'b0;
            data_d1_q <= '0;
            po_sum_q  <= '0;
            po_flag_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            f1_wr_q   <= f1_wr_d;
            f1_din_q  <= f1_din_d;
            f2_wr_q   <= f2_wr_d;
            f2_din_q  <= f2_din_d;
            rd_q      <= rd_d;
            rd_wb_q   <= rd_wb_d;
            s2_q      <= s2_d;
            s2_wb_q   <= s2_wb_d;
            data_d1_q <= data_d1_d;
            po_sum_q  <= po_sum_d;
            po_flag_q <= po_flag_d;
            err_q     <= err_d;
        end
    end

    // Row shift-up at T+2 uses FIFO read data directly, so write data is muxed
    assign fifo1_wr_en = f1_wr_q | (s2_q & s2_wb_q);
    assign fifo1_din   = s2_q ? fifo2_dout : f1_din_q;
    assign fifo2_wr_en = f2_wr_q | (s2_q & s2_wb_q);
    assign fifo2_din   = s2_q ? data_d1_q : f2_din_q;
    assign fifo1_rd_en = rd_q;
    assign fifo2_rd_en = rd_q;
    assign po_sum      = po_sum_q;
    assign po_flag     = po_flag_q;
    assign err         = err_q;

endmodule

// File: doc/fifo_sum_ctrl.md
Name: fifo_sum_ctrl

Overview:
- Sequencing controller for the row-sum datapath. It receives a frame of bytes from the UART receiver (pi_data / pi_flag) and treats the frame as a ROW_MAX x COL_MAX matrix, row-major.
- It drives two external single-clock FIFOs (fifo1, fifo2) as row delay lines.
- For every byte from row 2 onward it emits the column-wise sum of three vertically adjacent elements (rows r-2, r-1, r) to the UART transmit path.

Parameters:
- COL_MAX, 5, bytes per row (>=1).
- ROW_MAX, 4, rows per frame (>=3).

Ports:
- sys_clk, in, 1, system clock (50 MHz).
- sys_rst_n, in, 1, asynchronous active-low reset.
- pi_data, in, 8, received byte; valid only while pi_flag=1.
- pi_flag, in, 1, one-cycle strobe per received byte.
- fifo1_wr_en, out, 1, fifo1 write enable.
- fifo1_din, out, 8, fifo1 write data.
- fifo1_rd_en, out, 1, fifo1 read enable.
- fifo1_dout, in, 8, fifo1 read data; valid 1 cycle after rd_en (normal mode, not show-ahead).
- fifo1_empty, in, 1, fifo1 empty flag.
- fifo2_wr_en, out, 1, fifo2 write enable.
- fifo2_din, out, 8, fifo2 write data.
- fifo2_rd_en, out, 1, fifo2 read enable.
- fifo2_dout, in, 8, fifo2 read data; same 1-cycle latency.
- fifo2_empty, in, 1, fifo2 empty flag.
- po_sum, out, 10, three-element column sum.
- po_flag, out, 1, one-cycle strobe, po_sum valid.
- err, out, 1, sticky underflow error.

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0, col_cnt=0, row_cnt=0, state=WR_F1, pipeline registers cleared. External FIFO aclr is tied to ~sys_rst_n at top level, so reset mid-frame discards the partial frame. The first byte after reset is row 0, col 0.
- Counters:
  - col_cnt advances on each accepted pi_flag and wraps at COL_MAX-1 to 0.
  - row_cnt increments on col_cnt wrap and wraps at ROW_MAX-1 to 0, starting a new frame.
- States:
  - WR_F1 (row 0): on pi_flag, registered next cycle: fifo1_wr_en=1, fifo1_din=pi_data. At last column -> WR_F2.
  - WR_F2 (row 1): on pi_flag, registered next cycle: fifo2_wr_en=1, fifo2_din=pi_data. At last column -> SUM.
  - SUM (rows 2..ROW_MAX-1), per byte, pi_flag at cycle T:
    - T+1: fifo1_rd_en=fifo2_rd_en=1 (one cycle each); data_d1<=pi_data.
    - T+2: fifo1_dout/fifo2_dout valid; data_d2<=data_d1.
    - T+2, only if row_cnt is not ROW_MAX-1: fifo1_wr_en=1 with fifo1_din=fifo2_dout; fifo2_wr_en=1 with fifo2_din=data_d1. This shifts rows up by one.
    - T+3: po_sum = fifo1_dout + fifo2_dout + data_d2, zero-extended to 10 bits (max 765, no overflow); po_flag=1 for exactly one cycle.
    - At last column of row ROW_MAX-1 -> WR_F1.
- Latency: po_flag exactly 3 cycles after pi_flag. po_sum holds its value between strobes.
- End of frame: both FIFOs are empty one cycle after the final read (no writes on the last row). Each FIFO peaks at COL_MAX entries.
- Precondition: pi_flag strobes are at least 4 cycles apart (UART byte is about 52k cycles). The controller does not check this; a closer strobe is undefined.
- Underflow: if fifo1_empty or fifo2_empty=1 in the cycle rd_en is asserted, err<=1 and stays 1 until reset. The sum is still produced from the FIFO outputs as returned.
- Write-while-read on the same FIFO never occurs in the same cycle: reads are at T+1, writes at T+2.

Test Plan:
1. Reset, then 20 bytes 0x01..0x14 (COL_MAX=5, ROW_MAX=4) at UART rate -> 10 po_flag strobes; po_sum = 18,21,24,27,30,33,36,39,42,45; err=0; both FIFOs empty after the frame.
2. Byte stream of all 0xFF -> every po_sum=765 (0x2FD); no truncation.
3. Two back-to-back frames (40 bytes) -> second frame yields the same 10 sums as the first; col_cnt/row_cnt wrap to 0 between frames.
4. Assert sys_rst_n=0 after byte 12, release, send 20 fresh bytes -> only the 10 sums of the new frame appear, no stale data; all outputs 0 during reset.
5. Force fifo1_empty=1 during the first SUM read -> err=1 and stays 1 through later frames until reset.
6. Check timing on byte 11 of scenario 1 -> rd_en pulses at T+1, writes at T+2 (fifo1_din=0x06, fifo2_din=0x0B), po_flag at T+3 with po_sum=18.
